step_clock_gen: RTL and testbench

Quarter-phase clock and run-control generator that drives the control unit's stepper. It divides the system clock into step cycles of four quarter phases and produces the clock (clk_out), delayed clock (clk_d), enable window (clk_e) and set strobe (clk_s) on every step cycle. It also produces a one-cycle step_adv clock-enable that advances the stepper. Run/halt/single-step control stops the machine only at step or instruction boundaries, using the stepper's last-step bit as the return path.

---
 rtl/step_clock_gen_if.sv | 24 ++
 rtl/step_clock_gen.sv | 90 +++++++++
 tb/tb_step_clock_gen.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/step_clock_gen_if.sv
// Run-control and quarter-phase clock bundle between the stepper environment and step_clock_gen.
interface step_clock_gen_if;
  logic start;
  logic halt;
  logic step_once;
  logic step_last;
  logic clk_out;
  logic clk_d;
  logic clk_e;
  logic clk_s;
  logic step_adv;
  logic running;
  logic halted;

  modport master (
    output start, halt, step_once, step_last,
    input  clk_out, clk_d, clk_e, clk_s, step_adv, running, halted
  );

  modport slave (
    input  start, halt, step_once, step_last,
    output clk_out, clk_d, clk_e, clk_s, step_adv, running, halted
  );
endinterface

// File: rtl/step_clock_gen.sv
// Quarter-phase machine clock generator with run/halt/single-step control.
// Outputs are registered from the next-state decode, so inputs never reach outputs combinationally.
module step_clock_gen #(
  parameter int DIV = 1
) (
  input logic clk,
  input logic reset,
  step_clock_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, SINGLE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(DIV - 1);

  state_t     state, state_nxt;
  logic [1:0] q, q_nxt;
  logic [7:0] div_cnt, cnt_nxt;
  logic       qtr_end, cyc_end;
  logic       active_nxt, clk_out_nxt, clk_d_nxt, adv_nxt;

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    cnt_nxt   = div_cnt;
    qtr_end   = (div_cnt == CNT_LAST);
    cyc_end   = qtr_end && (q == 2'd3);

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          q_nxt     = 2'd0;
          cnt_nxt   = 8'd0;
        end else if (bus.step_once) begin
          state_nxt = SINGLE;
          q_nxt     = 2'd0;
          cnt_nxt   = 8'd0;
        end
      end
      RUN, SINGLE: begin
        if (qtr_end) begin
          cnt_nxt = 8'd0;
          q_nxt   = q + 2'd1;
        end else begin
          cnt_nxt = div_cnt + 8'd1;
        end
        // step_last is the pre-shift value, so a RUN stop lands just after step 6 completes
        if (cyc_end && ((state == SINGLE) || (bus.halt && bus.step_last))) begin
          state_nxt = IDLE;
          q_nxt     = 2'd3;
        end
      end
      default: begin
        state_nxt = IDLE;
        q_nxt     = 2'd3;
        cnt_nxt   = 8'd0;
      end
    endcase

    active_nxt  = (state_nxt != IDLE);
    clk_out_nxt = active_nxt && !q_nxt[1];
    clk_d_nxt   = active_nxt && (q_nxt[1] ^ q_nxt[0]);
    adv_nxt     = active_nxt && (q_nxt == 2'd3) && (cnt_nxt == CNT_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      q            <= 2'd3;
      div_cnt      <= 8'd0;
      bus.clk_out  <= 1'b0;
      bus.clk_d    <= 1'b0;
      bus.clk_e    <= 1'b0;
      bus.clk_s    <= 1'b0;
      bus.step_adv <= 1'b0;
      bus.running  <= 1'b0;
      bus.halted   <= 1'b1;
    end else begin
      state        <= state_nxt;
      q            <= q_nxt;
      div_cnt      <= cnt_nxt;
      bus.clk_out  <= clk_out_nxt;
      bus.clk_d    <= clk_d_nxt;
      bus.clk_e    <= clk_out_nxt | clk_d_nxt;
      bus.clk_s    <= clk_out_nxt & clk_d_nxt;
      bus.step_adv <= adv_nxt;
      bus.running  <= active_nxt;
      bus.halted   <= !active_nxt;
    end
  end
endmodule

// File: tb/tb_step_clock_gen.sv
// Two generators (DIV=1 and DIV=3) share stimulus; each is checked against a step-cycle position model.
module tb_step_clock_gen;
  localparam int DIV0 = 1;
  localparam int DIV1 = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic halt = 1'b0;
  logic step_once = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  step_clock_gen_if sif0 ();
  step_clock_gen_if sif1 ();

  step_clock_gen #(.DIV(DIV0)) dut0 (.clk(clk), .reset(reset), .bus(sif0.slave));
  step_clock_gen #(.DIV(DIV1)) dut1 (.clk(clk), .reset(reset), .bus(sif1.slave));

  always #5 clk = ~clk;

  // one-hot stepper environment, kept as a step number 1..6
  int stp [2];
  int adv_cnt [2];
  int m_mode [2];  // 0 idle, 1 run, 2 single
  int m_t [2];     // system-clock position inside the current step cycle
  logic [6:0] vec [2];

  assign sif0.start = start;     assign sif1.start = start;
  assign sif0.halt = halt;       assign sif1.halt = halt;
  assign sif0.step_once = step_once;
  assign sif1.step_once = step_once;
  assign sif0.step_last = (stp[0] == 6);
  assign sif1.step_last = (stp[1] == 6);

  assign vec[0] = {sif0.clk_out, sif0.clk_d, sif0.clk_e, sif0.clk_s, sif0.step_adv, sif0.running, sif0.halted};
  assign vec[1] = {sif1.clk_out, sif1.clk_d, sif1.clk_e, sif1.clk_s, sif1.step_adv, sif1.running, sif1.halted};

  function automatic int div_of(input int i);
    return (i == 0) ? DIV0 : DIV1;
  endfunction

  function automatic logic [6:0] exp_vec(input int mode, input int t, input int div);
    int qtr;
    logic o, d;
    if (mode == 0) return 7'b0000001;
    qtr = t / div;
    o = (qtr < 2);
    d = (qtr == 1) || (qtr == 2);
    return {o, d, o | d, o & d, (t == 4 * div - 1), 1'b1, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stp[0] <= 1;
      stp[1] <= 1;
    end else begin
      if (sif0.step_adv) stp[0] <= (stp[0] == 6) ? 1 : stp[0] + 1;
      if (sif1.step_adv) stp[1] <= (stp[1] == 6) ? 1 : stp[1] + 1;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] <= 0;
        m_t[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_mode[i] == 0) begin
          if (start) begin
            m_mode[i] <= 1;
            m_t[i] <= 0;
          end else if (step_once) begin
            m_mode[i] <= 2;
            m_t[i] <= 0;
          end
        end else if (m_t[i] == 4 * div_of(i) - 1) begin
          m_t[i] <= 0;
          if (m_mode[i] == 2 || (halt && stp[i] == 6)) m_mode[i] <= 0;
        end else begin
          m_t[i] <= m_t[i] + 1;
        end
      end
    end
  end

  initial begin
    adv_cnt[0] = 0;
    adv_cnt[1] = 0;
  end

  always @(negedge clk) begin
    check("model_div1", {25'd0, vec[0]}, {25'd0, exp_vec(m_mode[0], m_t[0], DIV0)});
    check("model_div3", {25'd0, vec[1]}, {25'd0, exp_vec(m_mode[1], m_t[1], DIV1)});
    adv_cnt[0] <= adv_cnt[0] + int'(sif0.step_adv);
    adv_cnt[1] <= adv_cnt[1] + int'(sif1.step_adv);
  end

  task automatic drive_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_stp0(input int tgt);
    int n;
    n = 0;
    while (stp[0] != tgt && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wait_step", {31'd0, stp[0] == tgt}, 32'd1);
  endtask

  task automatic wait_halted(input int inst);
    int n;
    n = 0;
    while (vec[inst][0] != 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wait_halted", {31'd0, vec[inst][0]}, 32'd1);
  endtask

  logic [3:0] tbl [4];
  int a0, a1;

  initial begin
    tbl[0] = 4'b1010;
    tbl[1] = 4'b1111;
    tbl[2] = 4'b0110;
    tbl[3] = 4'b0000;

    repeat (3) drive_cycle();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_div1", {25'd0, vec[0]}, 32'h01);
      check("idle_div3", {25'd0, vec[1]}, 32'h01);
    end

    // start pulse: literal phase table for both dividers
    drive_cycle(); start = 1'b1;
    drive_cycle(); start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      check("seq_div1", {28'd0, vec[0][6:3]}, {28'd0, tbl[(k - 1) % 4]});
      check("adv_div1", {31'd0, vec[0][2]}, {31'd0, (k % 4) == 0});
      check("seq_div3", {28'd0, vec[1][6:3]}, {28'd0, tbl[((k - 1) / 3) % 4]});
      check("adv_div3", {31'd0, vec[1][2]}, {31'd0, (k % 12) == 0});
    end
    drive_cycle(); start = 1'b1;
    drive_cycle(); start = 1'b0;

    // reset in q1 of the DIV=1 cycle
    begin
      int n;
      n = 0;
      while (vec[0][6:3] != 4'b1111 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("find_q1", {28'd0, vec[0][6:3]}, 32'hf);
    end
    #2 reset = 1'b1;
    #1;
    check("rst_async_div1", {25'd0, vec[0]}, 32'h01);
    check("rst_async_div3", {25'd0, vec[1]}, 32'h01);
    a0 = adv_cnt[0];
    drive_cycle(); reset = 1'b0;
    @(negedge clk);
    check("rst_no_adv", adv_cnt[0], a0);

    // halt held from start: exactly one instruction
    halt = 1'b1;
    drive_cycle(); start = 1'b1;
    drive_cycle(); start = 1'b0;
    a0 = adv_cnt[0];
    a1 = adv_cnt[1];
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 1) check("restart_q0", {28'd0, vec[0][6:3]}, 32'ha);
      if (k == 24) check("halt_before_div1", {31'd0, vec[0][0]}, 32'd0);
      if (k == 25) check("halt_after_div1", {31'd0, vec[0][0]}, 32'd1);
      if (k == 72) check("halt_before_div3", {31'd0, vec[1][0]}, 32'd0);
      if (k == 73) check("halt_after_div3", {31'd0, vec[1][0]}, 32'd1);
    end
    check("instr_adv_div1", adv_cnt[0] - a0, 32'd6);
    check("instr_adv_div3", adv_cnt[1] - a1, 32'd6);
    check("stepper_home0", stp[0], 32'd1);
    check("stepper_home1", stp[1], 32'd1);
    halt = 1'b0;

    // single step
    drive_cycle(); step_once = 1'b1;
    drive_cycle(); step_once = 1'b0;
    a0 = adv_cnt[0];
    a1 = adv_cnt[1];
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 5) check("single_end_div1", {31'd0, vec[0][0]}, 32'd1);
      if (k == 13) check("single_end_div3", {31'd0, vec[1][0]}, 32'd1);
    end
    check("single_adv_div1", adv_cnt[0] - a0, 32'd1);
    check("single_adv_div3", adv_cnt[1] - a1, 32'd1);

    // start wins over step_once
    drive_cycle(); start = 1'b1; step_once = 1'b1;
    drive_cycle(); start = 1'b0; step_once = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 8) check("start_wins_div1", {31'd0, vec[0][1]}, 32'd1);
      if (k == 16) check("start_wins_div3", {31'd0, vec[1][1]}, 32'd1);
    end
    drive_cycle(); start = 1'b1;
    drive_cycle(); start = 1'b0;

    // halt on step 3, dropped on step 5, re-raised on step 6
    wait_stp0(3); halt = 1'b1;
    wait_stp0(5); halt = 1'b0;
    check("no_stop", {31'd0, vec[0][1]}, 32'd1);
    wait_stp0(6); halt = 1'b1;
    a0 = adv_cnt[0];
    wait_halted(0);
    check("late_halt_adv", adv_cnt[0] - a0, 32'd1);
    check("late_halt_step", stp[0], 32'd1);
    wait_halted(1);
    halt = 1'b0;

    // randomized control traffic
    for (int k = 0; k < 3000; k++) begin
      drive_cycle();
      start = ($urandom_range(0, 40) == 0);
      step_once = ($urandom_range(0, 25) == 0);
      if ($urandom_range(0, 15) == 0) halt = ~halt;
      reset = ($urandom_range(0, 500) == 0);
    end
    drive_cycle();
    reset = 1'b0;
    start = 1'b0;
    step_once = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
